// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues in-order fetches on the SRAM-like bus,
// buffers returned words in a small queue and hands them to decode.
module if_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [69:0] fs_to_ds_bus
);

   localparam int QW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [4:0]    EX_ADEL   = 5'h04;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
   localparam logic [PW-1:0] PEND_LAST = PW'(MAX_OUT - 1);

   logic [31:0]   fetch_pc_reg;
   logic [31:0]   pend_mem [MAX_OUT];
   logic [PW-1:0] pend_rd_reg;
   logic [PW-1:0] pend_wr_reg;
   logic [69:0]   q_mem [DEPTH];
   logic [QW-1:0] q_rd_reg;
   logic [QW-1:0] q_wr_reg;
   logic [CW-1:0] q_cnt_reg;
   logic [OW-1:0] out_cnt_reg;
   logic [OW-1:0] discard_cnt_reg;
   logic          ex_pushed_reg;

   logic [OW-1:0] live_cnt;
   logic [OW-1:0] dok_dec;
   logic [7:0]    credit_used;
   logic          aligned;
   logic          accept;
   logic          resp;
   logic          stale;
   logic          q_full;
   logic          q_push_word;
   logic          q_push_ex;
   logic          q_push;
   logic          q_pop;
   logic [69:0]   q_wdata;

   function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
      return (p == PEND_LAST) ? '0 : p + PW'(1);
   endfunction

   // Queue credit counts only live requests; stale ones will be dropped on return.
   assign live_cnt    = out_cnt_reg - discard_cnt_reg;
   assign credit_used = 8'(live_cnt) + 8'(q_cnt_reg);
   assign aligned     = (fetch_pc_reg[1:0] == 2'b00);
   assign q_full      = (q_cnt_reg == DEPTH_C);

   assign inst_sram_req   = !reset && !redirect && aligned &&
                            (out_cnt_reg < MAX_OUT_C) && (credit_used < 8'(DEPTH));
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'h2;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_addr  = fetch_pc_reg;
   assign inst_sram_wdata = 32'h0;

   assign accept      = inst_sram_req && inst_sram_addr_ok;
   assign resp        = inst_sram_data_ok;
   assign dok_dec     = OW'(resp);
   assign stale       = resp && (discard_cnt_reg != '0);
   assign q_push_word = resp && !stale && !redirect;
   assign q_push_ex   = !redirect && !aligned && (out_cnt_reg == discard_cnt_reg) &&
                        !q_full && !ex_pushed_reg;
   assign q_push      = q_push_word || q_push_ex;
   assign q_pop       = fs_to_ds_valid && ds_allowin;
   assign q_wdata     = q_push_ex ? {1'b1, EX_ADEL, 32'h0, fetch_pc_reg}
                                  : {1'b0, 5'h0, inst_sram_rdata, pend_mem[pend_rd_reg]};

   assign fs_to_ds_valid = (q_cnt_reg != '0) && !redirect;
   assign fs_to_ds_bus   = (q_cnt_reg != '0) ? q_mem[q_rd_reg] : '0;

   always_ff @(posedge clk) begin
      if (accept) pend_mem[pend_wr_reg] <= fetch_pc_reg;
      if (q_push) q_mem[q_wr_reg] <= q_wdata;
   end

   // The pending FIFO tracks every bus transaction, stale or not, so it ignores redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_rd_reg <= '0;
         pend_wr_reg <= '0;
      end else begin
         if (accept) pend_wr_reg <= pend_next(pend_wr_reg);
         if (resp)   pend_rd_reg <= pend_next(pend_rd_reg);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_reg    <= RESET_PC;
         q_rd_reg        <= '0;
         q_wr_reg        <= '0;
         q_cnt_reg       <= '0;
         out_cnt_reg     <= '0;
         discard_cnt_reg <= '0;
         ex_pushed_reg   <= 1'b0;
      end else if (redirect) begin
         fetch_pc_reg    <= redirect_pc;
         q_rd_reg        <= '0;
         q_wr_reg        <= '0;
         q_cnt_reg       <= '0;
         out_cnt_reg     <= out_cnt_reg - dok_dec;
         discard_cnt_reg <= out_cnt_reg - dok_dec;
         ex_pushed_reg   <= 1'b0;
      end else begin
         if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
         if (q_push) q_wr_reg <= q_wr_reg + QW'(1);
         if (q_pop)  q_rd_reg <= q_rd_reg + QW'(1);
         q_cnt_reg   <= q_cnt_reg + CW'(q_push) - CW'(q_pop);
         out_cnt_reg <= out_cnt_reg + OW'(accept) - dok_dec;
         if (stale)     discard_cnt_reg <= discard_cnt_reg - OW'(1);
         if (q_push_ex) ex_pushed_reg   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: a queue-based reference model predicts
// request, address and decode-side outputs every cycle, plus directed scenarios.
module tb_if_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;
   localparam logic [4:0]  EX_ADEL  = 5'h04;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [69:0] fs_to_ds_bus;

   if_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // reference model: pending requests (with stale flag), decode queue, fetch pc
   logic [31:0] pend_pc [$];
   bit          pend_stale [$];
   logic [69:0] mq [$];
   logic [31:0] m_pc;
   bit          m_ex;

   // memory model: accepted addresses and the cycle each becomes returnable
   logic [31:0] mem_addr [$];
   int          mem_rdy [$];
   int          cyc;
   int          p_dok, lat_min, lat_jit;

   // observations of the DUT for directed checks
   logic [69:0] dlv_bus [$];
   int          dlv_cyc [$];
   logic        obs_req, obs_valid;
   logic [31:0] obs_addr;
   int          n_req_seen;

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'h1234abcd;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] v;
      v = $urandom;
      v[1:0] = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
      return v;
   endfunction

   task automatic model_clear();
      pend_pc.delete(); pend_stale.delete(); mq.delete();
      mem_addr.delete(); mem_rdy.delete();
      m_pc = RESET_PC; m_ex = 0;
   endtask

   // one clock cycle: caller has set redirect/addr_ok/allowin at the falling edge
   task automatic step();
      logic        e_req, e_valid, dok, s, ex_go;
      logic [69:0] e_bus;
      logic [31:0] rd, p;
      int          live;
      dok = (mem_addr.size() > 0) && (cyc >= mem_rdy[0]) && ($urandom_range(99) < p_dok);
      rd  = dok ? word_of(mem_addr[0]) : $urandom;
      inst_sram_data_ok = dok;
      inst_sram_rdata   = rd;
      live = 0;
      foreach (pend_stale[i]) if (!pend_stale[i]) live++;
      e_req   = !redirect && (m_pc[1:0] == 2'b00) && (pend_pc.size() < MAX_OUT) &&
                ((live + mq.size()) < DEPTH);
      e_valid = (mq.size() > 0) && !redirect;
      e_bus   = (mq.size() > 0) ? mq[0] : '0;
      #1;
      check("req", inst_sram_req, e_req);
      if (e_req) check("addr", inst_sram_addr, m_pc);
      check("valid", fs_to_ds_valid, e_valid);
      if (e_valid) check("bus", fs_to_ds_bus, e_bus);
      obs_req = inst_sram_req; obs_valid = fs_to_ds_valid; obs_addr = inst_sram_addr;
      if (inst_sram_req) n_req_seen++;
      if (fs_to_ds_valid && ds_allowin) begin
         dlv_bus.push_back(fs_to_ds_bus);
         dlv_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (dok) begin
         void'(mem_addr.pop_front());
         void'(mem_rdy.pop_front());
      end
      if (e_req && inst_sram_addr_ok) begin
         mem_addr.push_back(m_pc);
         mem_rdy.push_back(cyc + lat_min + $urandom_range(lat_jit));
      end
      if (redirect) begin
         if (dok) begin
            void'(pend_pc.pop_front());
            void'(pend_stale.pop_front());
         end
         foreach (pend_stale[i]) pend_stale[i] = 1;
         mq.delete();
         m_ex = 0;
         m_pc = redirect_pc;
      end else begin
         ex_go = (m_pc[1:0] != 2'b00) && (live == 0) && (mq.size() < DEPTH) && !m_ex;
         if (e_valid && ds_allowin) void'(mq.pop_front());
         if (dok) begin
            p = pend_pc.pop_front();
            s = pend_stale.pop_front();
            if (!s) mq.push_back({1'b0, 5'h0, rd, p});
         end
         if (ex_go) begin
            mq.push_back({1'b1, EX_ADEL, 32'h0, m_pc});
            m_ex = 1;
         end
         if (e_req && inst_sram_addr_ok) begin
            pend_pc.push_back(m_pc);
            pend_stale.push_back(0);
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n, input int p_aok, input int p_allow, input int p_redir);
      for (int i = 0; i < n; i++) begin
         redirect          = ($urandom_range(99) < p_redir);
         redirect_pc       = rand_pc();
         inst_sram_addr_ok = ($urandom_range(99) < p_aok);
         ds_allowin        = ($urandom_range(99) < p_allow);
         step();
         redirect = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("rst_req", inst_sram_req, 1'b0);
      check("rst_valid", fs_to_ds_valid, 1'b0);
      check("rst_bus", fs_to_ds_bus, 70'h0);
      redirect = 0; inst_sram_addr_ok = 0; inst_sram_data_ok = 0; ds_allowin = 0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc = 0;
   endtask

   initial begin
      logic [69:0] b;
      logic [31:0] pa, pb;
      reset = 1'b1; redirect = 0; redirect_pc = 0;
      inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0; ds_allowin = 0;
      p_dok = 100; lat_min = 1; lat_jit = 0; cyc = 0; n_req_seen = 0;
      model_clear();
      repeat (2) @(negedge clk);
      check("init_req", inst_sram_req, 1'b0);
      check("init_valid", fs_to_ds_valid, 1'b0);
      check("init_bus", fs_to_ds_bus, 70'h0);
      check("const_wr", inst_sram_wr, 1'b0);
      check("const_size", inst_sram_size, 2'h2);
      check("const_wstrb", inst_sram_wstrb, 4'h0);
      check("const_wdata", inst_sram_wdata, 32'h0);
      reset = 1'b0;

      // streaming: one delivery per cycle after a two-cycle fill
      run(8, 100, 100, 0);
      for (int i = 0; i < 3; i++) begin
         b = (dlv_bus.size() > i) ? dlv_bus[i] : '0;
         check("stream_pc", b[31:0], RESET_PC + 32'(4 * i));
         check("stream_cyc", (dlv_cyc.size() > i) ? dlv_cyc[i] : -1, 2 + i);
      end

      // backpressure: queue fills, fetch stops, nothing lost after release
      run(10, 100, 0, 0);
      check("bp_req", obs_req, 1'b0);
      check("bp_valid", obs_valid, 1'b1);
      dlv_bus.delete(); dlv_cyc.delete();
      run(8, 0, 100, 0);
      check("bp_count", dlv_bus.size(), DEPTH);
      for (int i = 1; i < dlv_bus.size(); i++) begin
         b = dlv_bus[i - 1]; pa = b[31:0];
         b = dlv_bus[i];     pb = b[31:0];
         check("bp_order", pb, pa + 32'd4);
      end

      // asynchronous reset mid-burst, then first fetch from RESET_PC
      run(5, 100, 100, 0);
      do_reset();
      lat_min = 4;
      inst_sram_addr_ok = 1; ds_allowin = 1;
      step();
      check("rst_first_req", obs_req, 1'b1);
      check("rst_first_addr", obs_addr, RESET_PC);
      step();

      // redirect with two requests outstanding
      redirect = 1; redirect_pc = 32'h80000180;
      step();
      redirect = 0;
      lat_min = 1;
      dlv_bus.delete(); dlv_cyc.delete();
      run(10, 100, 100, 0);
      b = (dlv_bus.size() > 0) ? dlv_bus[0] : '0;
      check("redir2_first_pc", b[31:0], 32'h80000180);

      // redirect coinciding with data_ok, one outstanding
      run(8, 0, 100, 0);
      inst_sram_addr_ok = 1;
      step();
      redirect = 1; redirect_pc = 32'h80000180; inst_sram_addr_ok = 0;
      step();
      check("redir_dok_seen", inst_sram_data_ok, 1'b1);
      redirect = 0; inst_sram_addr_ok = 1;
      dlv_bus.delete(); dlv_cyc.delete();
      step();
      check("redir_dok_req", obs_req, 1'b1);
      check("redir_dok_addr", obs_addr, 32'h80000180);
      run(5, 100, 100, 0);
      b = (dlv_bus.size() > 0) ? dlv_bus[0] : '0;
      check("redir_dok_first_pc", b[31:0], 32'h80000180);

      // misaligned redirect: single AdEL entry, no fetch
      redirect = 1; redirect_pc = 32'h80000002;
      step();
      redirect = 0;
      dlv_bus.delete(); dlv_cyc.delete(); n_req_seen = 0;
      run(8, 100, 100, 0);
      check("adel_reqs", n_req_seen, 0);
      check("adel_count", dlv_bus.size(), 1);
      b = (dlv_bus.size() > 0) ? dlv_bus[0] : '0;
      check("adel_entry", b, {1'b1, EX_ADEL, 32'h0, 32'h80000002});

      // randomised traffic with redirects and one reset
      redirect = 1; redirect_pc = 32'h00400000;
      step();
      redirect = 0;
      for (int k = 0; k < 30; k++) begin
         p_dok   = $urandom_range(30, 100);
         lat_min = 1 + $urandom_range(2);
         lat_jit = $urandom_range(3);
         if (k == 15) do_reset();
         run(50, $urandom_range(20, 100), $urandom_range(10, 100), 4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
